// File: rtl/dcache_pkg.sv
// Shared types and field positions for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } state_e;

    localparam int OFF_BITS   = 2;
    localparam int IDX_BITS   = 3;
    localparam int IDX_LSB    = OFF_BITS;
    localparam int TAG_LSB    = IDX_LSB + IDX_BITS;
    localparam int LINE_WORDS = 1 << OFF_BITS;

endpackage

// File: rtl/dcache_arrays.sv
// Tag/valid/data storage: async valid clear, one comb read port,
// one word-write port plus a line-fill port that sets tag and valid.
module dcache_arrays #(
    parameter int TAG_W  = 5,
    parameter int IDX_W  = 3,
    parameter int OFF_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [OFF_W-1:0]  i_rd_off,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [OFF_W-1:0]  i_wr_off,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_fill_en,
    input  logic [TAG_W-1:0]  i_fill_tag
);

    localparam int LINES = 1 << IDX_W;
    localparam int WORDS = 1 << OFF_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES][WORDS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only valid bits are cleared.
    always_ff @(posedge i_clk) begin
        if (i_fill_en) begin
            r_tag[i_wr_idx] <= i_fill_tag;
        end
        if (i_wr_en) begin
            r_data[i_wr_idx][i_wr_off] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx][i_rd_off];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-through, no-write-allocate data-cache controller
// between the core load/store port and a word-addressed data memory.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 3,
    parameter int OFF_W   = 2,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] CPU_A,
    input  logic [DATA_W-1:0] CPU_WD,
    input  logic              CPU_RE,
    input  logic              CPU_WE,
    output logic [DATA_W-1:0] CPU_RD,
    output logic              STALL,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [DATA_W-1:0] MEM_WD,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RD
);

    localparam int              TAG_W    = ADDR_W - TAG_LSB;
    localparam logic [3:0]      LAT_LAST = 4'(MEM_LAT - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(LINE_WORDS - 1);

    state_e r_state;
    state_e w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wd;
    logic [OFF_W-1:0]  r_word_cnt;
    logic [3:0]        r_lat_cnt;

    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_hit;
    logic              w_lat_done;

    logic              w_stall;
    logic [DATA_W-1:0] w_cpu_rd;
    logic [ADDR_W-1:0] w_mem_a;
    logic [DATA_W-1:0] w_mem_wd;
    logic              w_mem_we;
    logic              w_wr_en;
    logic [OFF_W-1:0]  w_wr_off;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_fill_en;

    // Idle looks up the live core address; busy states use the latched one.
    assign w_rd_addr  = (r_state == S_IDLE) ? CPU_A : r_addr;
    assign w_hit      = w_rd_valid &
                        (w_rd_tag == w_rd_addr[ADDR_W-1:TAG_LSB]);
    assign w_lat_done = (r_lat_cnt == LAT_LAST);

    dcache_arrays #(
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W),
        .DATA_W (DATA_W)
    ) u_arrays (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_rd_idx   (w_rd_addr[IDX_LSB +: IDX_W]),
        .i_rd_off   (w_rd_addr[OFF_W-1:0]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_addr[IDX_LSB +: IDX_W]),
        .i_wr_off   (w_wr_off),
        .i_wr_data  (w_wr_data),
        .i_fill_en  (w_fill_en),
        .i_fill_tag (r_addr[ADDR_W-1:TAG_LSB])
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_cpu_rd  = '0;
        w_mem_a   = '0;
        w_mem_wd  = '0;
        w_mem_we  = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_off  = r_addr[OFF_W-1:0];
        w_wr_data = r_wd;
        w_fill_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (CPU_WE) begin
                    w_stall = 1'b1;
                    w_next  = S_WRITE;
                end else if (CPU_RE) begin
                    if (w_hit) begin
                        w_cpu_rd = w_rd_data;
                    end else begin
                        w_stall = 1'b1;
                        w_next  = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                w_stall = 1'b1;
                w_mem_a = {r_addr[ADDR_W-1:OFF_W], r_word_cnt};
                if (w_lat_done) begin
                    w_wr_en   = 1'b1;
                    w_wr_off  = r_word_cnt;
                    w_wr_data = MEM_RD;
                    if (r_word_cnt == OFF_LAST) begin
                        w_fill_en = 1'b1;
                        w_next    = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                w_mem_a  = r_addr;
                w_mem_wd = r_wd;
                w_mem_we = (r_lat_cnt == 4'd0);
                w_stall  = !w_lat_done;
                if (w_lat_done) begin
                    w_wr_en = w_hit;
                    w_next  = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_addr     <= '0;
            r_wd       <= '0;
            r_word_cnt <= '0;
            r_lat_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_word_cnt <= '0;
                    r_lat_cnt  <= '0;
                    if (CPU_WE) begin
                        r_addr <= CPU_A;
                        r_wd   <= CPU_WD;
                    end else if (CPU_RE && !w_hit) begin
                        r_addr <= {CPU_A[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (w_lat_done) begin
                        r_lat_cnt  <= '0;
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                    end
                end
                S_WRITE: begin
                    if (w_lat_done) begin
                        r_lat_cnt <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                    end
                end
                default: begin
                    r_lat_cnt <= '0;
                end
            endcase
        end
    end

    // Reset forces the core/memory-facing outputs quiet even with a request held.
    assign STALL  = RST_N & w_stall;
    assign MEM_WE = RST_N & w_mem_we;
    assign CPU_RD = RST_N ? w_cpu_rd : '0;
    assign MEM_A  = RST_N ? w_mem_a  : '0;
    assign MEM_WD = RST_N ? w_mem_wd : '0;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench: one MEM_LAT=1 and one MEM_LAT=3 controller, each on its own memory model.
module tb_dcache_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic        a_rst_n, a_re, a_we, a_stall, a_mem_we;
    logic [9:0]  a_cpu_a, a_mem_a;
    logic [31:0] a_cpu_wd, a_rd, a_mem_wd, a_mem_rd;
    logic        b_rst_n, b_re, b_we, b_stall, b_mem_we;
    logic [9:0]  b_cpu_a, b_mem_a;
    logic [31:0] b_cpu_wd, b_rd, b_mem_wd, b_mem_rd;

    logic [31:0] ram_a [1024];
    logic [31:0] ram_b [1024];
    logic        mem_ready;
    logic [9:0]  alog [16];

    dcache_controller #(.MEM_LAT(1)) u_a (
        .CLK(clk), .RST_N(a_rst_n), .CPU_A(a_cpu_a), .CPU_WD(a_cpu_wd),
        .CPU_RE(a_re), .CPU_WE(a_we), .CPU_RD(a_rd), .STALL(a_stall),
        .MEM_A(a_mem_a), .MEM_WD(a_mem_wd), .MEM_WE(a_mem_we), .MEM_RD(a_mem_rd)
    );

    dcache_controller #(.MEM_LAT(3)) u_b (
        .CLK(clk), .RST_N(b_rst_n), .CPU_A(b_cpu_a), .CPU_WD(b_cpu_wd),
        .CPU_RE(b_re), .CPU_WE(b_we), .CPU_RD(b_rd), .STALL(b_stall),
        .MEM_A(b_mem_a), .MEM_WD(b_mem_wd), .MEM_WE(b_mem_we), .MEM_RD(b_mem_rd)
    );

    assign a_mem_rd = ram_a[a_mem_a];
    assign b_mem_rd = ram_b[b_mem_a];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) ram_a[i] <= (i < 256) ? 32'(255 - i) : 32'd0;
        end else if (a_mem_we) begin
            ram_a[a_mem_a] <= a_mem_wd;
        end
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) ram_b[i] <= (i < 256) ? 32'(255 - i) : 32'd0;
        end else if (b_mem_we) begin
            ram_b[b_mem_a] <= b_mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit s, input logic [9:0] a, input logic re,
                          input logic we, input logic [31:0] wd);
        if (s) begin
            b_cpu_a = a; b_re = re; b_we = we; b_cpu_wd = wd;
        end else begin
            a_cpu_a = a; a_re = re; a_we = we; a_cpu_wd = wd;
        end
    endtask

    task automatic load(input bit s, input logic [9:0] addr, output int ns,
                        output logic [31:0] rd, output logic [9:0] ma);
        ns = 0;
        for (int i = 0; i < 16; i++) alog[i] = '0;
        set_in(s, addr, 1'b1, 1'b0, 32'd0);
        #1;
        while ((s ? b_stall : a_stall) && ns < 200) begin
            if (ns < 16) alog[ns] = s ? b_mem_a : a_mem_a;
            ns++;
            @(posedge clk); #1;
        end
        rd = s ? b_rd : a_rd;
        ma = s ? b_mem_a : a_mem_a;
        @(posedge clk); #1;
        set_in(s, addr, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic store(input bit s, input logic [9:0] addr, input logic [31:0] wd,
                         output int ns, output int nwe, output logic [9:0] wa,
                         output logic [31:0] wdo, output logic [31:0] rd0);
        ns = 0; nwe = 0; wa = '0; wdo = '0;
        set_in(s, addr, 1'b1, 1'b1, wd);
        #1;
        rd0 = s ? b_rd : a_rd;
        for (int c = 0; c < 200; c++) begin
            if (s ? b_mem_we : a_mem_we) begin
                nwe++;
                wa  = s ? b_mem_a : a_mem_a;
                wdo = s ? b_mem_wd : a_mem_wd;
            end
            if (!(s ? b_stall : a_stall)) break;
            ns++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        set_in(s, addr, 1'b0, 1'b0, 32'd0);
    endtask

    int          ns, nwe;
    logic [31:0] rd, wdo, rd0;
    logic [9:0]  ma, wa;

    initial begin
        mem_ready = 1'b0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0);
        set_in(1'b1, '0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        mem_ready = 1'b1;

        set_in(1'b0, 10'h004, 1'b1, 1'b0, 32'd0);
        #1;
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_rd", a_rd, 32'd0);
        check("rst_mem_a", 32'(a_mem_a), 32'd0);
        check("rst_mem_we", 32'(a_mem_we), 32'd0);
        check("rst_mem_wd", a_mem_wd, 32'd0);
        set_in(1'b0, '0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;

        load(1'b0, 10'h004, ns, rd, ma);
        check("t1_stall", 32'(ns), 32'd5);
        check("t1_rd", rd, 32'd251);
        check("t1_a0", 32'(alog[0]), 32'h000);
        check("t1_a1", 32'(alog[1]), 32'h004);
        check("t1_a2", 32'(alog[2]), 32'h005);
        check("t1_a4", 32'(alog[4]), 32'h007);

        load(1'b0, 10'h006, ns, rd, ma);
        check("t2_stall", 32'(ns), 32'd0);
        check("t2_rd", rd, 32'd249);
        check("t2_mem_a", 32'(ma), 32'd0);

        load(1'b0, 10'h024, ns, rd, ma);
        check("t3_stall", 32'(ns), 32'd5);
        check("t3_rd", rd, 32'd219);
        check("t3_a1", 32'(alog[1]), 32'h024);
        check("t3_a4", 32'(alog[4]), 32'h027);
        load(1'b0, 10'h004, ns, rd, ma);
        check("t3_evict_stall", 32'(ns), 32'd5);
        check("t3_evict_rd", rd, 32'd251);
        load(1'b0, 10'h025, ns, rd, ma);
        check("t3_back_stall", 32'(ns), 32'd5);
        check("t3_back_rd", rd, 32'd218);

        store(1'b0, 10'h025, 32'hDEADBEEF, ns, nwe, wa, wdo, rd0);
        check("t4_stall", 32'(ns), 32'd1);
        check("t4_we_cycles", 32'(nwe), 32'd1);
        check("t4_mem_a", 32'(wa), 32'h025);
        check("t4_mem_wd", wdo, 32'hDEADBEEF);
        check("t4_we_prio_rd", rd0, 32'd0);
        check("t4_ram", ram_a[10'h025], 32'hDEADBEEF);
        load(1'b0, 10'h025, ns, rd, ma);
        check("t4_hit_stall", 32'(ns), 32'd0);
        check("t4_hit_rd", rd, 32'hDEADBEEF);

        store(1'b0, 10'h100, 32'h12345678, ns, nwe, wa, wdo, rd0);
        check("t5_stall", 32'(ns), 32'd1);
        check("t5_mem_a", 32'(wa), 32'h100);
        check("t5_ram", ram_a[10'h100], 32'h12345678);
        load(1'b0, 10'h100, ns, rd, ma);
        check("t5_miss_stall", 32'(ns), 32'd5);
        check("t5_rd", rd, 32'h12345678);

        store(1'b0, 10'h005, 32'hCAFE0005, ns, nwe, wa, wdo, rd0);
        check("t5b_ram", ram_a[10'h005], 32'hCAFE0005);
        load(1'b0, 10'h025, ns, rd, ma);
        check("t5b_keep_stall", 32'(ns), 32'd0);
        check("t5b_keep_rd", rd, 32'hDEADBEEF);

        load(1'b1, 10'h004, ns, rd, ma);
        check("t6_stall13", 32'(ns), 32'd13);
        check("t6_rd", rd, 32'd251);
        check("t6_a3", 32'(alog[3]), 32'h004);
        check("t6_a4", 32'(alog[4]), 32'h005);
        load(1'b1, 10'h008, ns, rd, ma);
        check("t6_b_stall", 32'(ns), 32'd13);
        check("t6_b_rd", rd, 32'd247);

        set_in(1'b1, 10'h00C, 1'b1, 1'b0, 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("t6_mid_mem_a", 32'(b_mem_a), 32'h00D);
        check("t6_mid_stall", 32'(b_stall), 32'd1);
        b_rst_n = 1'b0;
        #1;
        check("t6_rst_stall", 32'(b_stall), 32'd0);
        check("t6_rst_we", 32'(b_mem_we), 32'd0);
        check("t6_rst_mem_a", 32'(b_mem_a), 32'd0);
        @(posedge clk); #1;
        set_in(1'b1, '0, 1'b0, 1'b0, '0);
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        load(1'b1, 10'h004, ns, rd, ma);
        check("t6_post_stall", 32'(ns), 32'd13);
        check("t6_post_rd", rd, 32'd251);

        set_in(1'b1, 10'h040, 1'b0, 1'b1, 32'h00000001);
        @(posedge clk); #1;
        check("t6_wr_we", 32'(b_mem_we), 32'd1);
        check("t6_wr_stall", 32'(b_stall), 32'd1);
        b_rst_n = 1'b0;
        #1;
        check("t6_wr_rst_we", 32'(b_mem_we), 32'd0);
        check("t6_wr_rst_stall", 32'(b_stall), 32'd0);
        @(posedge clk); #1;
        set_in(1'b1, '0, 1'b0, 1'b0, '0);
        b_rst_n = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-through, no-write-allocate data-cache controller that sits between the RISC-V core's load/store port and the existing word-addressed Data_Memory (10-bit word address, 32-bit data, synchronous write).
Holds tag, valid and data arrays internally. On a read miss it stalls the core and refills a 4-word line from memory. Every store goes to memory; a store that hits also updates the cached copy.

Parameters:
ADDR_W, 10, word-address width (matches Data_Memory A)
DATA_W, 32, data width
IDX_W, 3, index bits (8 lines)
OFF_W, 2, word-offset bits (4 words/line)
MEM_LAT, 1, cycles per memory word access (legal 1..15)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
CPU_A  in  ADDR_W  core word address
CPU_WD  in  DATA_W  store data
CPU_RE  in  1  load request
CPU_WE  in  1  store request (priority over CPU_RE if both high)
CPU_RD  out  DATA_W  load data
STALL  out  1  core must hold request and pipeline
MEM_A  out  ADDR_W  Data_Memory address
MEM_WD  out  DATA_W  Data_Memory write data
MEM_WE  out  1  Data_Memory write enable
MEM_RD  in  DATA_W  Data_Memory read data

Behaviour:
- Address split: tag = A[9:5], index = A[4:2], offset = A[1:0]. hit = valid[index] & (tag_arr[index] == tag).
- Reset (async, RST_N=0): state IDLE; all valid bits cleared; counters 0; MEM_WE=0, STALL=0, CPU_RD=0, MEM_A=0, MEM_WD=0. Applies immediately, including mid-refill or mid-write. Data and tag arrays are not cleared.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - CPU_WE: STALL=1 combinationally; latch A/WD; go to WRITE.
  - CPU_RE & hit: STALL=0; CPU_RD = data[index][offset] combinationally (0-cycle hit).
  - CPU_RE & miss: STALL=1; latch line base {tag,index,2'b00}; go to REFILL.
  - No request: STALL=0.
- REFILL:
  - MEM_A = base + word_cnt, held for MEM_LAT cycles per word.
  - MEM_RD is sampled into data[index][word_cnt] on the last cycle of each word (lat_cnt == MEM_LAT-1).
  - After word 3 is captured: set valid[index]=1 and tag_arr[index]=tag, then go to IDLE. The core's held request now hits.
  - STALL=1 throughout. MEM_WE=0.
  - Read-miss penalty: 1 + 4*MEM_LAT stall cycles.
- WRITE:
  - MEM_A/MEM_WD = latched values. MEM_WE=1 only in the first WRITE cycle.
  - State lasts MEM_LAT cycles. STALL=1 except in the final cycle, where STALL=0 so the core retires the store on that edge.
  - On that final edge, if the latched address hits, update the cached word. Then go to IDLE.
  - Store miss: no allocation; tag and valid unchanged. Store stall: MEM_LAT cycles.
- Outside their states, MEM_A/MEM_WD are driven to 0. CPU_RD returns 0 when not a read hit in IDLE.
- The core must hold CPU_A/CPU_RE/CPU_WE stable while STALL=1. The controller works from latched copies, so changes during stall have no effect on the operation in flight.
- Counters: word_cnt is OFF_W bits wide and wraps 3→0 on refill completion. lat_cnt is 4 bits wide and resets to 0 on each word and on state entry.

Decomposition:
- Shared package (dcache_pkg): state encoding constants (IDLE=2'd0, REFILL=2'd1, WRITE=2'd2), field-position localparams (TAG_LSB, IDX_LSB), and line size.
- One sub-module, dcache_arrays: tag/valid/data storage with async valid clear, one combinational read port, and one word-write port.

Test Plan:
(Memory preloaded mem[i]=255-i for i=0..255. MEM_LAT=1 unless stated.)
1. After reset, load A=0x004 → STALL high 5 cycles; MEM_A steps 0x004..0x007; then STALL=0 and CPU_RD=251.
2. Load A=0x006 immediately after test 1 → hit; STALL=0 same cycle; CPU_RD=249; MEM_A stays 0.
3. Load A=0x024 (same index 1, tag 1) → miss and eviction; refill 0x024..0x027; CPU_RD=219. A subsequent load of 0x004 misses again.
4. Store A=0x025, WD=0xDEADBEEF (hit) → MEM_WE one cycle with MEM_A=0x025; STALL is 0 in the store's second cycle. A following load of 0x025 hits and returns 0xDEADBEEF.
5. Store A=0x100, WD=0x12345678 (miss) → memory written; cache not allocated. A following load of 0x100 misses, refills, and returns 0x12345678.
6. Separate MEM_LAT=3 build → read-miss stall is 13 cycles. Assert RST_N low during the 2nd refill word → STALL and MEM_WE drop immediately. After release, a load of a previously cached address misses.
